red_lane_serializer: RTL and testbench

//  Transmit side of the nibble-lane path used by the reduction datapath. Accepts one
//  16-bit word per handshake and emits its 4-bit lanes one per beat, with lane index,

---
 rtl/red_lane_serializer.sv | 97 +++++++++
 tb/tb_red_lane_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/red_lane_serializer.sv
// Word-to-nibble-lane serializer with lane index, last flag and running lane sum.
// Optional RED_LANE_PARITY_EN adds out_par, the even parity of the current lane.
module red_lane_serializer #(
  parameter  int WIDTH = 16,
  parameter  int LANE  = 4,
  localparam int BEATS = WIDTH / LANE,
  localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int SUMW  = LANE + IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic            in_msb_first,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LANE-1:0] out_lane,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic [SUMW-1:0] out_sum,
  output logic            busy
`ifdef RED_LANE_PARITY_EN
  ,
  output logic            out_par
`endif
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             msb_q;
  logic [LANE-1:0]  cap_lane;
  logic [LANE-1:0]  nxt_lane;

  // shreg holds only the lanes not yet presented on out_lane
  assign cap_lane = in_msb_first ? in_data[WIDTH-1 -: LANE]
                                 : in_data[LANE-1:0];
  assign nxt_lane = msb_q ? shreg[WIDTH-1 -: LANE]
                          : shreg[LANE-1:0];

  assign in_ready = !rst &&
    ((state == IDLE) ||
     ((state == SEND) && out_last && out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      msb_q     <= 1'b0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sum   <= '0;
      busy      <= 1'b0;
`ifdef RED_LANE_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (in_valid && in_ready) begin
      state     <= SEND;
      msb_q     <= in_msb_first;
      shreg     <= in_msb_first ? (in_data << LANE)
                                : (in_data >> LANE);
      out_valid <= 1'b1;
      busy      <= 1'b1;
      out_lane  <= cap_lane;
      out_idx   <= '0;
      out_last  <= (BEATS == 1);
      out_sum   <= SUMW'(cap_lane);
`ifdef RED_LANE_PARITY_EN
      out_par   <= ^cap_lane;
`endif
    end else if ((state == SEND) && out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        shreg    <= msb_q ? (shreg << LANE)
                          : (shreg >> LANE);
        out_lane <= nxt_lane;
        out_idx  <= out_idx + IDXW'(1);
        out_last <= (out_idx == IDXW'(BEATS - 2));
        out_sum  <= out_sum + SUMW'(nxt_lane);
`ifdef RED_LANE_PARITY_EN
        out_par  <= ^nxt_lane;
`endif
      end
    end
  end

endmodule

// File: tb/tb_red_lane_serializer.sv
// Bench for red_lane_serializer: directed vectors plus random traffic
// checked against a queue of expected beats computed per accepted word.
module tb_red_lane_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_lane;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [5:0]  out_sum;
  logic        busy;
`ifdef RED_LANE_PARITY_EN
  logic        out_par;
`endif

  red_lane_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane     (out_lane),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .out_sum      (out_sum),
    .busy         (busy)
`ifdef RED_LANE_PARITY_EN
    ,
    .out_par      (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane;
    int idx;
    int last;
    int sum;
  } beat_t;

  beat_t q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    post_rst = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int d, input bit msb);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.lane = (d >> (4 * (msb ? 3 - k : k))) & 15;
      s += b.lane;
      b.idx  = k;
      b.last = (k == 3);
      b.sum  = s;
      q.push_back(b);
    end
  endtask

  task automatic step(input bit iv, input int d, input bit msb,
                      input bit ordy, input bit r);
    bit exp_rdy, acc, xf;
    @(negedge clk);
    rst = r;
    in_valid = iv;
    in_data = 16'(d);
    in_msb_first = msb;
    out_ready = ordy;
    #1;
    if (r) begin
      chk("rdy_in_rst", int'(in_ready), 0);
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("busy", int'(busy), int'(q.size() != 0));
      if (post_rst) begin
        chk("rst_lane", int'(out_lane), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_sum", int'(out_sum), 0);
`ifdef RED_LANE_PARITY_EN
        chk("rst_par", int'(out_par), 0);
`endif
      end
      if (q.size() != 0) begin
        chk("lane", int'(out_lane), q[0].lane);
        chk("idx", int'(out_idx), q[0].idx);
        chk("last", int'(out_last), q[0].last);
        chk("sum", int'(out_sum), q[0].sum);
`ifdef RED_LANE_PARITY_EN
        chk("par", int'(out_par), int'(^(q[0].lane[3:0])));
`endif
      end
    end
    acc = !r && iv && exp_rdy;
    xf  = !r && (q.size() != 0) && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (xf) void'(q.pop_front());
      if (acc) push_word(d, msb);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_msb_first = 1'b0;
    out_ready = 1'b0;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    idle(1);

    step(1, 16'h1234, 0, 1, 0);
    idle(5);
    step(1, 16'h1234, 1, 1, 0);
    idle(5);

    step(1, 16'hABCD, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    idle(4);

    step(1, 16'hFFFF, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h0000, 0, 1, 0);
    step(1, 16'h0000, 0, 1, 0);
    idle(5);

    step(1, 16'h5678, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(1, 16'h0001, 0, 1, 0);
    idle(5);

    step(1, 16'h7F30, 0, 1, 0);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, int'($urandom & 16'hFFFF),
           $urandom % 2, ($urandom % 4) != 0,
           ($urandom % 120) == 0);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
